filter_readout_ctrl: RTL and testbench

Serial readout sequencer for the decimation filter output. It watches the filter's `new_data` strobe and drives the `shift` input of the filter's 12-bit load/shift register. It turns the register's `serial_data_out` into a framed, clocked serial stream for off-chip capture, and it detects and counts words lost when a new word arrives before the previous one has been transmitted.

---
 rtl/filter_readout_pkg.sv | 17 +
 rtl/readout_phase_timer.sv | 40 ++++
 rtl/filter_readout_ctrl.sv | 172 +++++++++++++++++
 tb/tb_filter_readout_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_readout_pkg.sv
// Shared types and constants for the filter serial readout sequencer.
package filter_readout_pkg;

  localparam int unsigned DROP_CNT_W  = 8;
  localparam int unsigned WORD_W_DEF  = 12;
  localparam int unsigned CLK_DIV_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_TRAIL,
    ST_GAP
  } state_e;

endpackage

// File: rtl/readout_phase_timer.sv
// Phase duration timer: reloads with CLK_DIV-1 on restart and counts down to zero.
module readout_phase_timer
  import filter_readout_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_last,
  output logic phase_last_next
);

  localparam int unsigned      CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The look-ahead lets the top register outputs that must be high in a phase's last cycle.
  assign phase_last      = (cnt_q == '0);
  assign phase_last_next = (cnt_d == '0);

endmodule

// File: rtl/filter_readout_ctrl.sv
// Serial readout sequencer: frames and clocks the filter shift register out MSB first
// and tracks words lost to early new_data strobes.
module filter_readout_ctrl
  import filter_readout_pkg::*;
#(
  parameter int unsigned WORD_W  = WORD_W_DEF,
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_data,
  input  logic                  serial_data_in,
  input  logic                  ovr_clr,
  output logic                  shift,
  output logic                  ser_clk,
  output logic                  ser_data,
  output logic                  ser_frame,
  output logic                  busy,
  output logic                  word_done,
  output logic                  overrun,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned      BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  state_e                  state_q, state_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    shift_q, shift_d;
  logic                    ser_clk_q, ser_clk_d;
  logic                    ser_data_q, ser_data_d;
  logic                    ser_frame_q, ser_frame_d;
  logic                    busy_q, busy_d;
  logic                    word_done_q, word_done_d;
  logic                    overrun_q, overrun_d;
  logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
  logic                    restart, drop, phase_last, phase_last_next;

  readout_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .restart        (restart),
    .phase_last     (phase_last),
    .phase_last_next(phase_last_next)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (new_data) state_d = ST_SETUP;
      ST_SETUP: begin
        if (new_data) begin
          drop = 1'b1;
        end else begin
          state_d = ST_LOW;
          bit_d   = '0;
        end
      end
      ST_LOW: begin
        if (new_data) begin
          drop    = 1'b1;
          state_d = ST_GAP;
        end else if (phase_last) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (new_data) begin
          drop    = 1'b1;
          state_d = ST_GAP;
        end else if (phase_last) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_TRAIL: begin
        if (new_data) begin
          state_d = ST_GAP;
        end else if (phase_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (new_data) begin
          drop = 1'b1;
        end else if (phase_last) begin
          state_d = ST_SETUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    restart = (state_d != state_q) || drop;
  end

  // Outputs are registered from the next state so each one lines up with its phase.
  always_comb begin
    ser_frame_d = (state_d == ST_SETUP) || (state_d == ST_LOW) ||
                  (state_d == ST_HIGH) || (state_d == ST_TRAIL);
    ser_clk_d   = (state_d == ST_HIGH);
    busy_d      = (state_d != ST_IDLE);
    shift_d     = (state_d == ST_LOW) && phase_last_next && (bit_d != LAST_BIT);

    ser_data_d = 1'b0;
    if ((state_d == ST_LOW) && (state_q != ST_LOW)) begin
      ser_data_d = serial_data_in;
    end else if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
      ser_data_d = ser_data_q;
    end

    // A TRAIL arrival in the last TRAIL cycle already has word_done showing.
    word_done_d = ((state_d == ST_TRAIL) && phase_last_next) ||
                  ((state_q == ST_TRAIL) && new_data && !phase_last);

    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (ovr_clr) begin
        drop_count_d = DROP_CNT_W'(1);
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end else if (ovr_clr) begin
      overrun_d    = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_q        <= '0;
      shift_q      <= 1'b0;
      ser_clk_q    <= 1'b0;
      ser_data_q   <= 1'b0;
      ser_frame_q  <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      ser_clk_q    <= ser_clk_d;
      ser_data_q   <= ser_data_d;
      ser_frame_q  <= ser_frame_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign shift      = shift_q;
  assign ser_clk    = ser_clk_q;
  assign ser_data   = ser_data_q;
  assign ser_frame  = ser_frame_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;
  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_filter_readout_ctrl.sv
// Scoreboard bench: three sequencers (CLK_DIV 2, 1, 3) each driving a model shift register.
module tb_filter_readout_ctrl;

  localparam int NDUT = 3;

  typedef struct {
    int unsigned idx;
    logic [11:0] word;
    int unsigned flen;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nd[NDUT], oc[NDUT], sh[NDUT], sck[NDUT], sd[NDUT];
  logic        frm[NDUT], bsy[NDUT], wd[NDUT], ovr[NDUT];
  logic [11:0] ld[NDUT];
  logic [7:0]  dc[NDUT];
  int unsigned n_chk = 0, n_pass = 0;
  int          cyc = 0;
  int unsigned exp_drops = 0;
  logic        exp_ovr = 1'b0;

  always #5 clk = ~clk;

  function automatic int unsigned div_of(input int unsigned i);
    return (i == 1) ? 1 : ((i == 2) ? 3 : 2);
  endfunction

  function automatic int unsigned flen_of(input int unsigned i);
    return 1 + 2 * div_of(i) * 12 + div_of(i);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned D = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
    logic [11:0] sr;
    always @(posedge clk) begin
      if (nd[g]) sr <= ld[g];
      else if (sh[g]) sr <= {sr[10:0], 1'b0};
    end
    filter_readout_ctrl #(
      .WORD_W (12),
      .CLK_DIV(D)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .new_data      (nd[g]),
      .serial_data_in(sr[11]),
      .ovr_clr       (oc[g]),
      .shift         (sh[g]),
      .ser_clk       (sck[g]),
      .ser_data      (sd[g]),
      .ser_frame     (frm[g]),
      .busy          (bsy[g]),
      .word_done     (wd[g]),
      .overrun       (ovr[g]),
      .drop_count    (dc[g])
    );
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: reconstruct each received word and pop the scoreboard on word_done.
  int unsigned run_len[NDUT], n_sh[NDUT], n_bit[NDUT];
  int          last_rise[NDUT];
  logic [11:0] rx[NDUT];
  logic        pf[NDUT], pc[NDUT];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        run_len[i] = 0; n_sh[i] = 0; n_bit[i] = 0; last_rise[i] = -1;
        rx[i] = '0; pf[i] = 1'b0; pc[i] = 1'b0;
      end else begin
        if (frm[i] && !pf[i]) begin
          run_len[i] = 0; n_sh[i] = 0; n_bit[i] = 0; last_rise[i] = -1; rx[i] = '0;
        end
        if (frm[i]) run_len[i]++;
        if (sh[i]) n_sh[i]++;
        if (sck[i] && !pc[i]) begin
          if (last_rise[i] >= 0) chk("bit_period", int'(cyc - last_rise[i]), 2 * div_of(i));
          last_rise[i] = cyc;
          rx[i] = {rx[i][10:0], sd[i]};
          n_bit[i]++;
        end
        if (wd[i]) begin
          if (sb_q.size() == 0) begin
            chk("word_done_expected", 0, 1);
          end else begin
            mon_e = sb_q.pop_front();
            chk("word_owner", i, mon_e.idx);
            chk("word_value", rx[i], mon_e.word);
            chk("bit_count", n_bit[i], 12);
            chk("shift_count", n_sh[i], 11);
            chk("frame_len", run_len[i], mon_e.flen);
          end
        end
        pf[i] = frm[i];
        pc[i] = sck[i];
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int unsigned i, input logic [11:0] w);
    ld[i] = w;
    nd[i] = 1'b1;
    step(1);
    nd[i] = 1'b0;
  endtask

  task automatic expect_word(input int unsigned i, input logic [11:0] w, input int unsigned fl);
    exp_t e;
    e.idx = i; e.word = w; e.flen = fl;
    sb_q.push_back(e);
  endtask

  task automatic note_drop(input int unsigned n);
    exp_drops += n;
    exp_ovr = 1'b1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_overrun"}, ovr[0], exp_ovr);
    chk({tag, "_drop_count"}, dc[0], (exp_drops > 255) ? 255 : exp_drops);
  endtask

  initial begin
    logic [11:0] w, w2, w3;
    int unsigned off;
    int unsigned fl0;
    fl0 = flen_of(0);
    for (int i = 0; i < NDUT; i++) begin
      nd[i] = 1'b0; oc[i] = 1'b0; ld[i] = '0;
    end
    rst = 1'b1;
    step(3);
    chk("reset_outputs", {sh[0], sck[0], sd[0], frm[0], bsy[0], wd[0], ovr[0], dc[0]}, 0);
    rst = 1'b0;
    step(2);

    // Basic word
    chk("frame_idle", frm[0], 0);
    expect_word(0, 12'hA5C, fl0);
    pulse(0, 12'hA5C);
    chk("frame_rise", frm[0], 1);
    step(fl0);
    chk("idle_after_word", bsy[0], 0);
    check_status("basic");

    // Back-to-back words at the minimum lossless spacing
    repeat (4) begin
      w = 12'($urandom_range(0, 4095));
      expect_word(0, w, fl0);
      pulse(0, w);
      step(fl0 + $urandom_range(0, 3));
    end
    check_status("clean");

    // Arrival in the first and in the last TRAIL cycle
    for (int k = 0; k < 2; k++) begin
      w = 12'($urandom);
      w2 = 12'($urandom);
      off = fl0 - 1 + k;
      expect_word(0, w, off);
      expect_word(0, w2, fl0);
      pulse(0, w);
      step(off - 1);
      pulse(0, w2);
      chk("trail_word_done", wd[0], (k == 0) ? 1 : 0);
      chk("trail_gap0", frm[0], 0);
      step(1);
      chk("trail_gap1", frm[0], 0);
      step(1);
      chk("trail_setup", frm[0], 1);
      check_status("trail");
      step(fl0 + 2);
    end

    // Abort during bit 5
    w = 12'($urandom);
    pulse(0, w);
    off = $urandom_range(22, 25);
    step(off - 1);
    expect_word(0, 12'h123, fl0);
    pulse(0, 12'h123);
    note_drop(1);
    chk("abort_gap0", frm[0], 0);
    step(1);
    chk("abort_gap1", frm[0], 0);
    step(1);
    chk("abort_setup", frm[0], 1);
    check_status("abort");
    step(fl0 + 2);

    // Random aborts anywhere in the bit phases
    repeat (3) begin
      w = 12'($urandom);
      w2 = 12'($urandom);
      pulse(0, w);
      step($urandom_range(2, 49) - 1);
      expect_word(0, w2, fl0);
      pulse(0, w2);
      note_drop(1);
      step(fl0 + 4);
    end
    check_status("rand_abort");

    // Drop while in SETUP stretches SETUP by one cycle
    w = 12'($urandom);
    w2 = 12'($urandom);
    expect_word(0, w2, fl0 + 1);
    pulse(0, w);
    pulse(0, w2);
    note_drop(1);
    step(fl0 + 2);

    // Drop while in GAP restarts the gap
    w = 12'($urandom);
    w2 = 12'($urandom);
    w3 = 12'($urandom);
    pulse(0, w);
    step(9);
    pulse(0, w2);
    expect_word(0, w3, fl0);
    pulse(0, w3);
    note_drop(2);
    chk("gap_restart0", frm[0], 0);
    step(1);
    chk("gap_restart1", frm[0], 0);
    step(1);
    chk("gap_restart_setup", frm[0], 1);
    step(fl0 + 2);
    check_status("setup_gap");

    // 300 drops held in SETUP saturate the counter
    w = 12'($urandom);
    expect_word(0, w, fl0 + 300);
    ld[0] = w;
    nd[0] = 1'b1;
    step(301);
    nd[0] = 1'b0;
    note_drop(300);
    check_status("saturate");
    step(fl0 + 2);

    oc[0] = 1'b1;
    step(1);
    oc[0] = 1'b0;
    exp_drops = 0;
    exp_ovr = 1'b0;
    check_status("clear");

    // Clear and drop together: the drop wins
    w = 12'($urandom);
    w2 = 12'($urandom);
    pulse(0, w);
    step(9);
    expect_word(0, w2, fl0);
    ld[0] = w2;
    nd[0] = 1'b1;
    oc[0] = 1'b1;
    step(1);
    nd[0] = 1'b0;
    oc[0] = 1'b0;
    exp_drops = 0;
    note_drop(1);
    check_status("clear_vs_drop");
    step(fl0 + 4);

    // Reset at bit 7, then a clean 0xFFF
    w = 12'($urandom);
    pulse(0, w);
    step($urandom_range(30, 33) - 1);
    chk("pre_reset_busy", bsy[0], 1);
    rst = 1'b1;
    #1;
    chk("reset_async_outputs", {sh[0], sck[0], sd[0], frm[0], bsy[0], wd[0], ovr[0], dc[0]}, 0);
    step(2);
    rst = 1'b0;
    exp_drops = 0;
    exp_ovr = 1'b0;
    step(1);
    expect_word(0, 12'hFFF, fl0);
    pulse(0, 12'hFFF);
    step(fl0 + 2);
    check_status("post_reset");

    // Divider sweep
    for (int i = 1; i < NDUT; i++) begin
      expect_word(i, 12'h801, flen_of(i));
      pulse(i, 12'h801);
      step(flen_of(i) + 3);
      w = 12'($urandom);
      expect_word(i, w, flen_of(i));
      pulse(i, w);
      step(flen_of(i) + 3);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
